// File: rtl/hazard_pkg.sv
// Shared types and decode constants for the MIPS hazard/flush sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_INT      = 2'd2,
    ST_INT_MASK = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  localparam logic [31:0] ERET_WORD = 32'h42000018;

  // True for SPECIAL instructions that touch HI/LO and must wait for the mult/div unit.
  function automatic logic is_md_dep(input logic [31:0] instr);
    logic [5:0] fn;
    fn = instr[5:0];
    return (instr[31:26] == OP_SPECIAL) &&
           ((fn == FN_MFHI) || (fn == FN_MFLO) || (fn == FN_MULT) ||
            (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU));
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy down-counter: load on issue, decrement while busy, flag zero.
module md_busy_cnt
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero_c
);

  // Saturates at zero so a stray decrement can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/hazard_seq_ctrl.sv
// Hazard/flush sequencer: load-use bubbles, mult/div holds, interrupt flush and masking.
// Interrupt sequencing (INT, INT_MASK) is only built when HAZ_INT_CTRL_EN is defined.
module hazard_seq_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic        md_startE,
  input  logic        md_divE,
  input  logic        irq,
  output logic        stallF,
  output logic        stallD,
  output logic        clrE,
  output logic        intclr,
  output logic        epc_we,
  output logic        md_busy
);

  state_t           state, state_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt, cnt_init;
  logic [4:0]       rtE;
  logic             load_use, md_dep, hz, in_int;

  // Load-use: lw in EX writing a register that ID reads; a nop never hazards.
  assign rtE      = instrE[20:16];
  assign load_use = (instrE[31:26] == OP_LW) && (rtE != 5'd0) && (instrD != 32'd0) &&
                    ((rtE == instrD[25:21]) || (rtE == instrD[20:16]));
  assign md_dep   = is_md_dep(instrD);
  assign cnt_init = CNT_W'((md_divE ? DIV_CYCLES : MULT_CYCLES) - 32'd2);

`ifdef HAZ_INT_CTRL_EN
  logic unused_instrE;
  assign unused_instrE = ^{instrE[25:21], instrE[15:0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{instrE[25:21], instrE[15:0], irq};
`endif

  md_busy_cnt u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_init),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero_c   (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_n;
  end

  // Next state and per-state controls; mult/div issue outranks a pending irq.
  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    md_busy  = 1'b0;
    intclr   = 1'b0;
    epc_we   = 1'b0;
    in_int   = 1'b0;
    case (state)
      ST_RUN: begin
        if (md_startE) begin
          cnt_load = 1'b1;
          state_n  = ST_MD_BUSY;
        end
`ifdef HAZ_INT_CTRL_EN
        else if (irq) begin
          state_n = ST_INT;
        end
`endif
      end
      ST_MD_BUSY: begin
        md_busy = 1'b1;
        if (cnt_zero) state_n = ST_RUN;
        else          cnt_dec = 1'b1;
      end
`ifdef HAZ_INT_CTRL_EN
      ST_INT: begin
        intclr  = 1'b1;
        epc_we  = 1'b1;
        in_int  = 1'b1;
        state_n = ST_INT_MASK;
      end
      ST_INT_MASK: begin
        if (instrD == ERET_WORD) state_n = ST_RUN;
      end
`endif
      default: state_n = ST_RUN;
    endcase
  end

  // Stall sources OR together; the flush cycle never holds the front end.
  assign hz     = load_use | (md_busy & md_dep);
  assign stallF = hz & ~in_int;
  assign stallD = hz & ~in_int;
  assign clrE   = hz;

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Scoreboard bench for hazard_seq_ctrl: directed plan items plus randomized traffic
// checked against a cycle-level reference model.
module tb_hazard_seq_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

`ifdef HAZ_INT_CTRL_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrD, instrE;
  logic        md_startE, md_divE, irq;
  logic        stallF, stallD, clrE, intclr, epc_we, md_busy;

  hazard_seq_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .instrD    (instrD),
    .instrE    (instrE),
    .md_startE (md_startE),
    .md_divE   (md_divE),
    .irq       (irq),
    .stallF    (stallF),
    .stallD    (stallD),
    .clrE      (clrE),
    .intclr    (intclr),
    .epc_we    (epc_we),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] outs;  // {stallF, stallD, clrE, intclr, epc_we, md_busy}
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: mode 0 normal, 1 mult/div occupied, 2 flush cycle, 3 masked.
  int   mode = 0;
  int   busy_left = 0;

  function automatic bit lu_hazard(input logic [31:0] d, input logic [31:0] e);
    int op_e, rt_e, rs_d, rt_d;
    op_e = int'(e >> 26);
    rt_e = int'((e >> 16) & 32'd31);
    rs_d = int'((d >> 21) & 32'd31);
    rt_d = int'((d >> 16) & 32'd31);
    return (op_e == 35) && (rt_e != 0) && (d != 0) && (rt_e == rs_d || rt_e == rt_d);
  endfunction

  function automatic bit reads_hilo(input logic [31:0] d);
    int op, fn;
    op = int'(d >> 26);
    fn = int'(d & 32'd63);
    return (op == 0) && (fn == 16 || fn == 18 || (fn >= 24 && fn <= 27));
  endfunction

  // Expected outputs for this cycle, then advance the model across the next edge.
  task automatic model_cycle(input logic [31:0] d, input logic [31:0] e, input bit ms,
                             input bit md, input bit iq, input bit advance, output logic [5:0] o);
    bit lu, sf, cl, ic, bz;
    lu = lu_hazard(d, e);
    sf = lu; cl = lu; ic = 0; bz = 0;
    case (mode)
      1: begin
        bz = 1;
        sf = lu | reads_hilo(d);
        cl = sf;
      end
      2: begin
        ic = 1;
        sf = 0;
      end
      default: ;
    endcase
    o = {sf, sf, cl, ic, ic, bz};
    if (advance) begin
      case (mode)
        0: begin
          if (ms) begin
            mode = 1;
            busy_left = int'(md ? DIV_N : MULT_N) - 1;
          end else if (INT_EN && iq) begin
            mode = 2;
          end
        end
        1: begin
          busy_left = busy_left - 1;
          if (busy_left == 0) mode = 0;
        end
        2: mode = 3;
        3: if (d == 32'h42000018) mode = 0;
        default: mode = 0;
      endcase
    end
  endtask

  task automatic step(input logic [31:0] d, input logic [31:0] e, input bit ms,
                      input bit md, input bit iq, input string tag);
    exp_t x;
    @(posedge clk); #1;
    reset = 1'b1;
    instrD = d; instrE = e; md_startE = ms; md_divE = md; irq = iq;
    model_cycle(d, e, ms, md, iq, 1'b1, x.outs);
    x.tag = tag;
    q.push_back(x);
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must drop before the next edge.
  task automatic reset_step(input string tag);
    exp_t x;
    @(posedge clk); #1;
    reset = 1'b0;
    instrD = '0; instrE = '0; md_startE = 1'b0; md_divE = 1'b0; irq = 1'b0;
    mode = 0; busy_left = 0;
    model_cycle(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, x.outs);
    x.tag = tag;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [5:0] got;
      x = q.pop_front();
      got = {stallF, stallD, clrE, intclr, epc_we, md_busy};
      n_cmp++;
      if (got !== x.outs) begin
        n_err++;
        $display("FAIL %s @%0t: {stallF,stallD,clrE,intclr,epc_we,md_busy} got=%b expected=%b",
                 x.tag, $time, got, x.outs);
      end
    end
  end

  function automatic logic [31:0] rand_instrD();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1, 2:    return {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[15:6], 6'h20};
      3:       return {6'h00, r[25:6], 6'($urandom_range(16, 27))};
      4:       return 32'h42000018;
      5:       return {6'h23, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] rand_instrE();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    return {6'h23, r[25:21], 5'($urandom_range(0, 3)), r[15:0]};
      2:       return 32'd0;
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] LW5   = 32'h8C050000;  // lw $5, 0($0)
  localparam logic [31:0] LW0   = 32'h8C000000;  // lw $0, 0($0)
  localparam logic [31:0] ADD   = 32'h00A73020;  // add $6, $5, $7
  localparam logic [31:0] MFLO  = 32'h00001012;  // mflo $2
  localparam logic [31:0] ERET  = 32'h42000018;

  initial begin
    reset = 1'b0;
    instrD = '0; instrE = '0; md_startE = 1'b0; md_divE = 1'b0; irq = 1'b0;
    reset_step("reset_idle");
    reset_step("reset_hold");

    step(ADD, LW5, 0, 0, 0, "lu_hit");
    step(ADD, 32'd0, 0, 0, 0, "lu_cleared");
    step(ADD, LW0, 0, 0, 0, "lu_rt0");
    step(32'd0, LW5, 0, 0, 0, "lu_nop");

    step(32'd0, 32'd0, 1, 0, 0, "mult_issue");
    for (int i = 0; i < 6; i++) step(MFLO, 32'd0, 0, 0, 0, "mult_mflo_hold");

    step(32'd0, 32'd0, 1, 1, 1, "div_irq_issue");
    for (int i = 0; i < 12; i++) step(32'd0, 32'd0, 0, 0, 1, "div_irq_wait");
    step(ERET, 32'd0, 0, 0, 0, "eret");
    step(32'd0, 32'd0, 0, 0, 0, "after_eret");

    step(32'd0, 32'd0, 0, 0, 1, "irq_pulse");
    step(ERET, 32'd0, 0, 0, 0, "int_eret_ignored");
    step(32'd0, 32'd0, 0, 0, 1, "masked_irq");
    step(32'd0, 32'd0, 0, 0, 0, "masked_idle");
    step(ERET, 32'd0, 0, 0, 0, "unmask");
    step(32'd0, 32'd0, 0, 0, 1, "irq_again");
    step(32'd0, 32'd0, 0, 0, 0, "flush_again");
    step(ERET, 32'd0, 0, 0, 0, "unmask2");

    step(32'd0, 32'd0, 1, 0, 0, "mult_before_reset");
    reset_step("reset_mid_busy");
    step(MFLO, LW5, 0, 0, 0, "release_cycle");
    step(MFLO, 32'd0, 0, 0, 0, "after_release");

    for (int i = 0; i < 20; i++) step(32'd0, 32'd0, 0, 0, 1, "irq_level");
    step(ERET, 32'd0, 0, 0, 0, "irq_level_eret");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) reset_step("rand_reset");
      else step(rand_instrD(), rand_instrE(), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "random");
    end

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_seq_ctrl.md
# hazard_seq_ctrl

Pipeline hazard and flush sequencer for the 5-stage MIPS core. It drives the stall inputs of IF/ID and the `clr`/`intclr` inputs of the ID/EX register. It produces load-use bubbles, holds dependent instructions while the multi-cycle mult/div unit is busy, and sequences the one-cycle interrupt flush. It then masks further interrupts until `eret` reaches ID.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu, including the issue cycle.
- `DIV_CYCLES`, default 10: busy cycles for div/divu, including the issue cycle.

- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instrD`  in  32  instruction in ID.
- `instrE`  in  32  instruction in EX.
- `md_startE`  in  1  mult/div issued from EX this cycle.
- `md_divE`  in  1  qualifies `md_startE`: 1 = div/divu, 0 = mult/multu.
- `irq`  in  1  level-sensitive external interrupt request.
- `stallF`  out  1  hold PC.
- `stallD`  out  1  hold IF/ID.
- `clrE`  out  1  to ID/EX `clr`; inserts a bubble.
- `intclr`  out  1  to ID/EX `intclr`; interrupt flush.
- `epc_we`  out  1  CP0 EPC capture strobe.
- `md_busy`  out  1  mult/div unit occupied.

## Operation
States: RUN, MD_BUSY, INT, INT_MASK. A 4-bit down-counter `cnt` tracks mult/div occupancy.

**Load-use hazard (all states).** Asserted when all of the following hold:
- `instrE[31:26]==6'h23` (lw);
- `rtE!=0`;
- `rtE==instrD[25:21]` or `rtE==instrD[20:16]`.

Effect: `stallF=stallD=clrE=1` for that cycle. A nop (`instrD==0`) never hazards.

**RUN**
- `md_startE=1` → MD_BUSY, with `cnt` loaded to `(md_divE?DIV_CYCLES:MULT_CYCLES)-2`.
- Otherwise, `irq=1` → INT.
- `md_startE` has priority; `irq` is deferred, not lost, because it is a level.

**MD_BUSY**
- `md_busy=1`.
- If `instrD` is SPECIAL (opcode 0) with funct 0x10 (mfhi), 0x12 (mflo), or 0x18–0x1B (mult/div), drive `stallF=stallD=clrE=1`.
- `cnt` decrements each cycle. When `cnt==0` → RUN.
- `irq` is ignored until RUN is reached.

**INT** (exactly one cycle)
- `intclr=1`, `epc_we=1`, `stallF=stallD=0`.
- Next state: INT_MASK.

**INT_MASK**
- `irq` is ignored.
- When `instrD==32'h42000018` (eret in ID) → RUN next cycle.
- Load-use and MD stalls still apply.

**Output combination**
- Stall sources are ORed.
- `intclr` does not suppress `clrE`; ID/EX handles both.
- All outputs are combinational from state, `cnt` and inputs. State and `cnt` are registered.

## Timing
- Reset (asynchronous, `reset=0`): state=RUN, `cnt=0`. With `instrD=instrE=0`, every output is 0. Deassertion takes effect at the next rising edge.
- Load-use stall: zero latency, same cycle as the hazard. It lasts exactly one cycle because the bubble clears `instrE` at the next edge.
- `md_busy` rises the cycle after `md_startE` and stays high for exactly N−1 cycles (N = MULT_CYCLES or DIV_CYCLES). Counting the issue cycle, occupancy is N.
- `irq` seen high in RUN at edge k → `intclr` high during cycle k+1 only.
- Simultaneous `md_startE` and `irq` in RUN: MD wins. INT follows one cycle after MD_BUSY exits, provided `irq` is still high.
- eret in ID during INT: ignored; INT always proceeds to INT_MASK.
- Reset mid-MD_BUSY or mid-INT_MASK returns the block immediately to RUN with `cnt=0`.
- `cnt` never underflows. Legal parameter range is 2..16.

## Configuration
- `HAZ_INT_CTRL_EN` defined: full behaviour as above.
- `HAZ_INT_CTRL_EN` undefined:
  - INT and INT_MASK are not built;
  - `irq` is ignored;
  - `intclr` and `epc_we` are tied to 0;
  - load-use and MD stalls are unchanged.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum;
  - opcode/funct constants: `OP_LW`, `FN_MFHI`, `FN_MFLO`, `FN_MULT`..`FN_DIVU`;
  - `ERET_WORD=32'h42000018`.
- One sub-module, `md_busy_cnt`, holds the load, decrement and zero-detect counter for mult/div occupancy.
- Decode and the state machine stay in the top level.

## Test plan
1. `instrE=lw $5`, `instrD=add $6,$5,$7` → `stallF=stallD=clrE=1` for 1 cycle. Same pair with `rt=$0` → no stall.
2. `md_startE=1`, `md_divE=0`, then `instrD=mflo` held → `md_busy` high for 4 cycles, stall for 4 cycles, release on cycle 5.
3. `md_startE=1`, `md_divE=1` with `irq=1` in the same cycle → 9 busy cycles, then `intclr`/`epc_we` one cycle after RUN is re-entered.
4. `irq` pulse in RUN → `intclr=1` one cycle later. A second `irq` is ignored until `instrD=32'h42000018`, after which the next `irq` causes a flush.
5. Assert `reset=0` at `cnt=3` in MD_BUSY → `md_busy=0` immediately; after release, the block is in RUN with no stall.
6. Build without `HAZ_INT_CTRL_EN`, hold `irq=1` for 20 cycles → `intclr` and `epc_we` stay 0.
